// File: rtl/aes_blk_serializer.sv
// Serialises 128-bit AES blocks into a 32-bit AXI-Stream through a 2-entry block FIFO.
// Optional build macro AES_OUT_BYTE_SWAP_EN byte-reverses every output word.
module aes_blk_serializer #(
  parameter int unsigned BLK_S  = 128,
  parameter int unsigned WORD_S = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [BLK_S-1:0]  in_blk,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [WORD_S-1:0] m00_axis_tdata,
  output logic              m00_axis_tvalid,
  input  logic              m00_axis_tready,
  output logic              m00_axis_tlast,
  output logic              busy
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state, state_nxt;
  logic [1:0]        wcnt, wcnt_nxt;
  logic [1:0]        occ, occ_nxt;
  logic              wr_ptr, rd_ptr;
  logic              push, pop;
  logic [BLK_S:0]    fifo_mem [2];
  logic [BLK_S:0]    head;
  logic [WORD_S-1:0] words [4];
  logic [WORD_S-1:0] word;

  assign in_ready = (occ != 2'd2);
  assign push     = in_valid && in_ready;
  assign pop      = (state == SEND) && (wcnt == 2'd3) && m00_axis_tready;
  assign head     = fifo_mem[rd_ptr];
  assign busy     = (state == SEND) || (occ != 2'd0);

  always_comb begin
    occ_nxt = occ;
    case ({push, pop})
      2'b10:   occ_nxt = occ + 2'd1;
      2'b01:   occ_nxt = occ - 2'd1;
      default: occ_nxt = occ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      occ    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      occ <= occ_nxt;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
    end
  end

  // Payload storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= {in_last, in_blk};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  // Staying in SEND when the post-pop occupancy is non-zero avoids a bubble between blocks.
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    case (state)
      IDLE: begin
        if (occ != 2'd0) begin
          state_nxt = SEND;
          wcnt_nxt  = '0;
        end
      end
      SEND: begin
        if (m00_axis_tready) begin
          if (wcnt == 2'd3) begin
            wcnt_nxt = '0;
            if (occ_nxt == 2'd0) state_nxt = IDLE;
          end else begin
            wcnt_nxt = wcnt + 2'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    for (int unsigned k = 0; k < 4; k++) begin
      words[k] = head[BLK_S-1-WORD_S*k -: WORD_S];
    end
    word = words[wcnt];
  end

  always_comb begin
    m00_axis_tvalid = 1'b0;
    m00_axis_tlast  = 1'b0;
    m00_axis_tdata  = '0;
    if (state == SEND) begin
      m00_axis_tvalid = 1'b1;
      m00_axis_tlast  = (wcnt == 2'd3) && head[BLK_S];
`ifdef AES_OUT_BYTE_SWAP_EN
      m00_axis_tdata  = {word[7:0], word[15:8], word[23:16], word[31:24]};
`else
      m00_axis_tdata  = word;
`endif
    end
  end

endmodule

// File: doc/aes_blk_serializer.md
AES_BLK_SERIALIZER -- requirements
Module: aes_blk_serializer

Interface
REQ-001 Parameter BLK_S, default 128: width of one AES block in bits; the only supported value is 128.
REQ-002 Parameter WORD_S, default 32: AXI-Stream data width in bits; the only supported value is 32.
REQ-003 clock  input  1  single clock; all logic is on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_blk  input  128  processed block from the AES controller; bits [127:96] form word 0.
REQ-006 in_valid  input  1  in_blk and in_last are valid.
REQ-007 in_last  input  1  in_blk is the final block of the current request.
REQ-008 in_ready  output  1  the block is accepted when in_valid and in_ready are both high.
REQ-009 m00_axis_tdata  output  32  output stream word.
REQ-010 m00_axis_tvalid  output  1  output word is valid.
REQ-011 m00_axis_tready  input  1  downstream can accept a word.
REQ-012 m00_axis_tlast  output  1  high on the final word of a request.
REQ-013 busy  output  1  high when the FIFO is non-empty or a block is being sent.

Function
REQ-014 The block SHALL hold a 2-entry block FIFO; each entry is {in_last, in_blk} (129 bits), with a 2-bit occupancy counter (0..2).
- Write/read pointers are 1 bit each and wrap 1->0.
REQ-015 in_ready SHALL equal (occupancy != 2) and SHALL depend only on registered state, never on m00_axis_tready.
REQ-016 A push and a pop in the same cycle SHALL leave occupancy unchanged.
- With occupancy 2, no push can occur, because in_ready is low.
REQ-017 The send FSM SHALL have two states, IDLE and SEND, and a 2-bit word counter wcnt.
REQ-018 IDLE -> SEND when occupancy != 0; wcnt is set to 0 on that transition.
- The FIFO head is presented on the next cycle; first-word latency from an accepted block into an empty FIFO is 2 cycles.
REQ-019 In SEND, m00_axis_tvalid SHALL be 1 and m00_axis_tdata SHALL be word wcnt of the FIFO head.
- Word k = in_blk[127-32k -: 32].
REQ-020 The word counter SHALL advance only when m00_axis_tvalid and m00_axis_tready are both high.
- tdata and tlast SHALL stay stable while tvalid is high and tready is low.
REQ-021 When wcnt=3 and the word is accepted, the FIFO head SHALL be popped.
- The FSM SHALL then stay in SEND with wcnt=0 if another entry remains, with no bubble cycle; otherwise it goes to IDLE.
REQ-022 m00_axis_tlast SHALL be 1 only when wcnt=3 and the head entry's last flag is 1.
REQ-023 In IDLE, m00_axis_tvalid, m00_axis_tlast and m00_axis_tdata SHALL be 0.
REQ-024 busy = (state == SEND) || (occupancy != 0).
REQ-025 in_blk and in_last SHALL be ignored when in_valid is low, including when in_ready is high.
REQ-026 A block with in_last=0 followed by a gap SHALL NOT cause tlast; the request simply stays open.

Reset
REQ-027 Asserting reset at any time, including mid-block, SHALL asynchronously drive:
- state=IDLE, wcnt=0, occupancy=0, both pointers=0;
- m00_axis_tvalid=0, m00_axis_tlast=0, m00_axis_tdata=0, busy=0, in_ready=1.
REQ-028 After reset is released, the FIFO contents are discarded; partially sent blocks SHALL NOT resume.

Configuration
REQ-029 With macro AES_OUT_BYTE_SWAP_EN defined, each output word SHALL be byte-reversed: tdata[31:24]<-w[7:0], tdata[23:16]<-w[15:8], tdata[15:8]<-w[23:16], tdata[7:0]<-w[31:24].
- This matches kernel little-endian 32-bit word order.
REQ-030 Without AES_OUT_BYTE_SWAP_EN, tdata SHALL be word k unmodified; timing is identical in both builds.

Verification
REQ-031 Single block, tready=1, swap off:
- Stimulus: in_blk=69c4e0d86a7b0430d8cdb78070b4c55a, in_last=1.
- Response: words 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a on consecutive cycles, starting 2 cycles after accept; tlast only on the 4th word.
REQ-032 Same stimulus, swap on: words d8e0c469, 30047b6a, 80b7cdd8, 5ac5b470.
REQ-033 Back-pressure: slave tready OSC, 2 cycles low / 6 cycles high, 3 blocks, last flags 0,0,1.
- Response: 12 words in order with no loss; tdata stable while stalled; exactly one tlast, on word 12.
REQ-034 FIFO full: tready=0, push 3 blocks back to back.
- Response: in_ready falls after the 2nd accept; the 3rd block is held until word 3 of block 1 is accepted.
REQ-035 Reset mid-block: assert reset after word 1 of 2 queued blocks.
- Response: outputs 0 immediately and busy=0; a new block after release starts at word 0.
REQ-036 Throughput: 4 blocks back to back, tready=1.
- Response: 16 contiguous tvalid cycles with no gap between blocks.
